// File: rtl/pe_kernel_feeder.sv
// pe_kernel_feeder: loads a kernel burst into a local register file, then streams it to a PE for a set number of passes.
// Optional PE_KERNEL_REUSE_EN: a start with reuse replays the stored words without reloading.
module pe_kernel_feeder #(
   parameter int depth = 4,
   parameter int W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [depth-1:0] cfgLen,
   input  logic [7:0]       cfgRep,
   input  logic             reuse,
   input  logic             wrValid,
   output logic             wrReady,
   input  logic [W-1:0]     wrData,
   input  logic             peStall,
   output logic [W-1:0]     kernelOut,
   output logic             kernelValid,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
   state_t state;
   logic [W-1:0] mem [1<<depth];
   logic [depth-1:0] len, wrPtr, rdPtr;
   logic [7:0] rep, pass;
   logic loaded, wrFire, useStored;
   assign wrFire = (state == LOAD) && wrValid;
`ifdef PE_KERNEL_REUSE_EN
   assign useStored = reuse && loaded;
`else
   logic unusedReuse;
   assign unusedReuse = reuse;
   assign useStored = 1'b0;
`endif
   // Storage is deliberately left unreset.
   always_ff @(posedge CLK)
      if (wrFire) mem[wrPtr] <= wrData;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         len         <= '0;
         rep         <= '0;
         wrPtr       <= '0;
         rdPtr       <= '0;
         pass        <= '0;
         loaded      <= 1'b0;
         wrReady     <= 1'b0;
         kernelOut   <= '0;
         kernelValid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rep   <= cfgRep;
               wrPtr <= '0;
               rdPtr <= '0;
               pass  <= '0;
               busy  <= 1'b1;
               if (useStored) state <= STREAM;
               else begin
                  len     <= cfgLen;
                  wrReady <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: if (wrValid) begin
               wrPtr <= wrPtr + 1'b1;
               if (wrPtr == len) begin
                  loaded  <= 1'b1;
                  wrReady <= 1'b0;
                  state   <= STREAM;
               end
            end
            STREAM: if (peStall) kernelValid <= 1'b0;
            else begin
               kernelOut   <= mem[rdPtr];
               kernelValid <= 1'b1;
               rdPtr       <= (rdPtr == len) ? '0 : rdPtr + 1'b1;
               if (rdPtr == len) begin
                  pass <= pass + 8'd1;
                  if (pass == rep) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               kernelValid <= 1'b0;
               done        <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_kernel_feeder.sv
// tb_pe_kernel_feeder: directed checks of load, multi-pass streaming, stalls, boundaries and reset.
module tb_pe_kernel_feeder;
   logic CLK = 0, RST = 1, start = 0, reuse = 0, wrValid = 0, peStall = 0;
   logic [3:0] cfgLen = 0;
   logic [7:0] cfgRep = 0;
   logic [15:0] wrData = 0, kernelOut;
   logic wrReady, kernelValid, busy, done;
   int assertCnt = 0, failCnt = 0;
   logic [15:0] wv [16];
   logic [15:0] got [$];
   int doneCnt, doneCycle, idleCycle, stalls;
   bit doneOnLast, timedOut, loadOk;

   pe_kernel_feeder #(.depth(4), .W(16)) dut (
      .CLK(CLK), .RST(RST), .start(start), .cfgLen(cfgLen), .cfgRep(cfgRep), .reuse(reuse),
      .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData), .peStall(peStall),
      .kernelOut(kernelOut), .kernelValid(kernelValid), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic cyc;
      @(posedge CLK);
      #1;
   endtask

   task automatic startJob(input logic [3:0] l, input logic [7:0] r, input logic ru);
      cfgLen = l; cfgRep = r; reuse = ru; start = 1;
      cyc();
      start = 0; reuse = 0;
   endtask

   task automatic loadWords(input int n, input bit gaps);
      int i = 0;
      bit hs;
      for (int c = 0; c < 200 && i < n; c++) begin
         wrValid = gaps ? (c % 2 == 0) : 1'b1;
         wrData = wv[i];
         hs = wrValid && wrReady;
         cyc();
         if (hs) i++;
      end
      wrValid = 0;
      loadOk = (i == n);
   endtask

   task automatic runStream(input int stallPer, input int startAt, input int maxCyc);
      got.delete();
      doneCnt = 0; doneCycle = -1; idleCycle = -1; doneOnLast = 0; stalls = 0; timedOut = 1;
      for (int c = 1; c <= maxCyc; c++) begin
         peStall = (stallPer > 0) && (c % stallPer == 0);
         start = (c == startAt);
         if (peStall && doneCycle < 0) stalls++;
         cyc();
         if (kernelValid) got.push_back(kernelOut);
         if (done) begin doneCnt++; doneCycle = c; doneOnLast = kernelValid; end
         if (!busy) begin idleCycle = c; timedOut = 0; break; end
      end
      peStall = 0; start = 0;
   endtask

   task automatic test_reset;
      RST = 1;
      #3;
      assertCnt++; if ({wrReady, kernelValid, busy, done} !== 4'b0) begin failCnt++; $display("FAIL reset_ctrl: got %b required 0000", {wrReady, kernelValid, busy, done}); end
      assertCnt++; if (kernelOut !== 16'h0) begin failCnt++; $display("FAIL reset_data: got %h required 0000", kernelOut); end
      RST = 0;
      cyc();
   endtask

   task automatic test_basic;
      for (int i = 0; i < 4; i++) wv[i] = 16'hA0 + 16'(i);
      startJob(3, 0, 0);
      assertCnt++; if ({busy, wrReady} !== 2'b11) begin failCnt++; $display("FAIL basic_start: busy,wrReady got %b required 11", {busy, wrReady}); end
      loadWords(4, 0);
      assertCnt++; if (!loadOk || wrReady !== 1'b0) begin failCnt++; $display("FAIL basic_load: loadOk=%0d wrReady=%b required 1,0", loadOk, wrReady); end
      runStream(0, 0, 50);
      assertCnt++; if (timedOut || got.size() != 4) begin failCnt++; $display("FAIL basic_count: got %0d words timeout=%0d required 4", got.size(), timedOut); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         assertCnt++; if (got[i] !== wv[i]) begin failCnt++; $display("FAIL basic_word%0d: got %h required %h", i, got[i], wv[i]); end
      end
      assertCnt++; if (doneCnt != 1 || !doneOnLast || doneCycle != 4) begin failCnt++; $display("FAIL basic_done: cnt=%0d withLast=%0d cycle=%0d required 1,1,4", doneCnt, doneOnLast, doneCycle); end
      assertCnt++; if (idleCycle != 5) begin failCnt++; $display("FAIL basic_idle: busy low at %0d required 5", idleCycle); end
   endtask

   task automatic test_repeat;
      logic [15:0] exp;
      wv[0] = 16'h11; wv[1] = 16'h22;
      startJob(1, 2, 0);
      loadWords(2, 0);
      cfgLen = 0; cfgRep = 0;
      runStream(0, 3, 50);
      assertCnt++; if (timedOut || got.size() != 6) begin failCnt++; $display("FAIL repeat_count: got %0d words required 6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         exp = (i % 2 == 0) ? 16'h11 : 16'h22;
         assertCnt++; if (got[i] !== exp) begin failCnt++; $display("FAIL repeat_word%0d: got %h required %h", i, got[i], exp); end
      end
      assertCnt++; if (doneCnt != 1 || doneCycle != 6) begin failCnt++; $display("FAIL repeat_done: cnt=%0d cycle=%0d required 1,6", doneCnt, doneCycle); end
      cyc();
      assertCnt++; if ({busy, wrReady} !== 2'b00) begin failCnt++; $display("FAIL start_in_stream: busy,wrReady got %b required 00", {busy, wrReady}); end
   endtask

   task automatic test_gaps_stalls;
      for (int i = 0; i < 16; i++) wv[i] = 16'h100 + 16'(i * 7);
      startJob(15, 0, 0);
      loadWords(16, 1);
      assertCnt++; if (!loadOk) begin failCnt++; $display("FAIL gaps_load: loadOk got 0 required 1"); end
      runStream(3, 0, 100);
      assertCnt++; if (timedOut || got.size() != 16) begin failCnt++; $display("FAIL gaps_count: got %0d words required 16", got.size()); end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         assertCnt++; if (got[i] !== wv[i]) begin failCnt++; $display("FAIL gaps_word%0d: got %h required %h", i, got[i], wv[i]); end
      end
      assertCnt++; if (doneCycle != 16 + stalls) begin failCnt++; $display("FAIL stall_bubbles: done at %0d required %0d", doneCycle, 16 + stalls); end
   endtask

   task automatic test_boundaries;
      int bad = 0;
      wv[0] = 16'hBEEF;
      startJob(0, 255, 0);
      loadWords(1, 0);
      runStream(0, 0, 400);
      foreach (got[i]) if (got[i] !== 16'hBEEF) bad++;
      assertCnt++; if (timedOut || got.size() != 256 || bad != 0) begin failCnt++; $display("FAIL rep256: words=%0d bad=%0d required 256,0", got.size(), bad); end
      assertCnt++; if (doneCycle != 256 || doneCnt != 1) begin failCnt++; $display("FAIL rep256_done: cycle=%0d cnt=%0d required 256,1", doneCycle, doneCnt); end
      wrValid = 1; wrData = 16'hDEAD; bad = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (wrReady !== 1'b0 || busy !== 1'b0) bad++;
      end
      wrValid = 0;
      assertCnt++; if (bad != 0) begin failCnt++; $display("FAIL idle_write: %0d cycles with wrReady/busy high required 0", bad); end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      for (int i = 0; i < 8; i++) wv[i] = 16'h300 + 16'(i);
      startJob(7, 1, 0);
      loadWords(8, 0);
      for (int c = 0; c < 30 && n < 5; c++) begin
         cyc();
         if (kernelValid) begin
            assertCnt++; if (kernelOut !== wv[n]) begin failCnt++; $display("FAIL mid_word%0d: got %h required %h", n, kernelOut, wv[n]); end
            n++;
         end
      end
      assertCnt++; if (n != 5) begin failCnt++; $display("FAIL mid_count: got %0d words required 5", n); end
      #2 RST = 1;
      #1;
      assertCnt++; if ({wrReady, kernelValid, busy, done} !== 4'b0 || kernelOut !== 16'h0) begin failCnt++; $display("FAIL async_reset: ctrl=%b data=%h required 0000,0000", {wrReady, kernelValid, busy, done}, kernelOut); end
      #3 RST = 0;
      cyc();
      test_basic();
   endtask

`ifdef PE_KERNEL_REUSE_EN
   task automatic test_reuse;
      wv[0] = 16'h5; wv[1] = 16'h6;
      startJob(1, 0, 0);
      loadWords(2, 0);
      runStream(0, 0, 20);
      wrValid = 1; wrData = 16'hDEAD;
      cyc(); cyc();
      wrValid = 0;
      startJob(3, 1, 1);
      assertCnt++; if ({busy, wrReady} !== 2'b10) begin failCnt++; $display("FAIL reuse_start: busy,wrReady got %b required 10", {busy, wrReady}); end
      runStream(0, 0, 20);
      assertCnt++; if (timedOut || got.size() != 4) begin failCnt++; $display("FAIL reuse_count: got %0d words required 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         assertCnt++; if (got[i] !== wv[i % 2]) begin failCnt++; $display("FAIL reuse_word%0d: got %h required %h", i, got[i], wv[i % 2]); end
      end
      assertCnt++; if (doneCycle != 4) begin failCnt++; $display("FAIL reuse_done: cycle %0d required 4", doneCycle); end
      #2 RST = 1;
      #3 RST = 0;
      cyc();
      startJob(1, 0, 1);
      assertCnt++; if (wrReady !== 1'b1) begin failCnt++; $display("FAIL reuse_after_reset: wrReady got %b required 1", wrReady); end
      #2 RST = 1;
      #3 RST = 0;
      cyc();
   endtask
`else
   task automatic test_reuse;
      wv[0] = 16'h5; wv[1] = 16'h6;
      startJob(1, 0, 0);
      loadWords(2, 0);
      runStream(0, 0, 20);
      startJob(1, 0, 1);
      assertCnt++; if (wrReady !== 1'b1) begin failCnt++; $display("FAIL reuse_ignored: wrReady got %b required 1", wrReady); end
      #2 RST = 1;
      #3 RST = 0;
      cyc();
   endtask
`endif

   initial begin
      #12;
      test_reset();
      test_basic();
      test_repeat();
      test_gaps_stalls();
      test_boundaries();
      test_reset_mid();
      test_reuse();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
